// File: rtl/vote_session_ctrl.sv
// Session controller for a 5-voter, 3-candidate one-hot ballot tally.
// Round-robin grant, one ballot per voter, closes on all-voted or timeout.
module vote_session_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  req,
    input  logic [14:0] ballot,
    output logic [4:0]  grant,
    output logic [4:0]  voted,
    output logic        busy,
    output logic        done,
    output logic [2:0]  result,
    output logic [2:0]  cnt0,
    output logic [2:0]  cnt1,
    output logic [2:0]  cnt2,
    output logic [2:0]  invalid_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OPEN  = 2'd1;
    localparam logic [1:0] S_TALLY = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    voted_q, voted_d;
    logic [2:0]    cnt0_q, cnt0_d;
    logic [2:0]    cnt1_q, cnt1_d;
    logic [2:0]    cnt2_q, cnt2_d;
    logic [2:0]    inv_q, inv_d;
    logic [2:0]    result_q, result_d;

    logic [4:0] elig;
    logic       gvalid;
    logic [2:0] gidx;
    logic [2:0] gballot;
    int         idx;

    // First eligible voter searching upward from ptr, wrapping at 5.
    always_comb begin
        elig   = req & ~voted_q;
        gvalid = 1'b0;
        gidx   = 3'd0;
        idx    = 0;
        if (state_q == S_OPEN) begin
            for (int k = 0; k < 5; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= 5) idx = idx - 5;
                if (!gvalid && elig[idx]) begin
                    gvalid = 1'b1;
                    gidx   = 3'(idx);
                end
            end
        end
        grant = gvalid ? 5'(5'b00001 << gidx) : 5'b00000;
    end

    always_comb begin
        case (gidx)
            3'd0:    gballot = ballot[2:0];
            3'd1:    gballot = ballot[5:3];
            3'd2:    gballot = ballot[8:6];
            3'd3:    gballot = ballot[11:9];
            3'd4:    gballot = ballot[14:12];
            default: gballot = 3'b000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        timer_d  = timer_q;
        voted_d  = voted_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        cnt2_d   = cnt2_q;
        inv_d    = inv_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_OPEN;
                    ptr_d    = 3'd0;
                    timer_d  = '0;
                    voted_d  = 5'b00000;
                    cnt0_d   = 3'd0;
                    cnt1_d   = 3'd0;
                    cnt2_d   = 3'd0;
                    inv_d    = 3'd0;
                    result_d = 3'b000;
                end
            end
            S_OPEN: begin
                timer_d = timer_q + 1'b1;
                if (gvalid) begin
                    voted_d[gidx] = 1'b1;
                    ptr_d = (gidx == 3'd4) ? 3'd0 : gidx + 3'd1;
                    case (gballot)
                        3'b001:  cnt0_d = cnt0_q + 3'd1;
                        3'b010:  cnt1_d = cnt1_q + 3'd1;
                        3'b100:  cnt2_d = cnt2_q + 3'd1;
                        default: inv_d  = inv_q + 3'd1;
                    endcase
                end
                if (&voted_d || timer_q == TW'(TIMEOUT - 1))
                    state_d = S_TALLY;
            end
            S_TALLY: begin
                // Strict maximum only; ties and an all-zero tally give 000.
                if (cnt0_q > cnt1_q && cnt0_q > cnt2_q)
                    result_d = 3'b001;
                else if (cnt1_q > cnt0_q && cnt1_q > cnt2_q)
                    result_d = 3'b010;
                else if (cnt2_q > cnt0_q && cnt2_q > cnt1_q)
                    result_d = 3'b100;
                else
                    result_d = 3'b000;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= 3'd0;
            timer_q  <= '0;
            voted_q  <= 5'b00000;
            cnt0_q   <= 3'd0;
            cnt1_q   <= 3'd0;
            cnt2_q   <= 3'd0;
            inv_q    <= 3'd0;
            result_q <= 3'b000;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            timer_q  <= timer_d;
            voted_q  <= voted_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
            cnt2_q   <= cnt2_d;
            inv_q    <= inv_d;
            result_q <= result_d;
        end
    end

    assign voted       = voted_q;
    assign busy        = (state_q == S_OPEN) || (state_q == S_TALLY);
    assign done        = (state_q == S_DONE);
    assign result      = result_q;
    assign cnt0        = cnt0_q;
    assign cnt1        = cnt1_q;
    assign cnt2        = cnt2_q;
    assign invalid_cnt = inv_q;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: table of whole sessions plus
// hand-written grant-order, duplicate, start-ignore and reset sequences.
module tb_vote_session_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  req;
    logic [14:0] ballot;
    logic [4:0]  grant;
    logic [4:0]  voted;
    logic        busy;
    logic        done;
    logic [2:0]  result;
    logic [2:0]  cnt0;
    logic [2:0]  cnt1;
    logic [2:0]  cnt2;
    logic [2:0]  invalid_cnt;

    int nchecks = 0;
    int nerrors = 0;

    vote_session_ctrl #(.TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst(rst), .start(start), .req(req), .ballot(ballot),
        .grant(grant), .voted(voted), .busy(busy), .done(done),
        .result(result), .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2),
        .invalid_cnt(invalid_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] req;
        logic [14:0] ballot;
        logic [2:0] c0;
        logic [2:0] c1;
        logic [2:0] c2;
        logic [2:0] inv;
        logic [2:0] res;
        logic [4:0] vt;
        int         lat;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Ballot word built as {E,D,C,B,A}.
    function automatic logic [14:0] bw(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [2:0] d,
                                       input logic [2:0] e);
        return {e, d, c, b, a};
    endfunction

    task automatic run_session(input vec_t v);
        int n;
        req = v.req;
        ballot = v.ballot;
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        check({v.name, " latency"}, n, v.lat);
        check({v.name, " done"}, done, 1);
        check({v.name, " busy"}, busy, 0);
        check({v.name, " cnt0"}, cnt0, v.c0);
        check({v.name, " cnt1"}, cnt1, v.c1);
        check({v.name, " cnt2"}, cnt2, v.c2);
        check({v.name, " invalid"}, invalid_cnt, v.inv);
        check({v.name, " result"}, result, v.res);
        check({v.name, " voted"}, voted, v.vt);
        check({v.name, " grant"}, grant, 0);
    endtask

    initial begin
        vecs[0] = '{"t1_win0", 5'b11111,
                    bw(3'b001, 3'b001, 3'b010, 3'b100, 3'b001),
                    3'd3, 3'd1, 3'd1, 3'd0, 3'b001, 5'b11111, 6};
        vecs[1] = '{"t2_tie", 5'b11111,
                    bw(3'b010, 3'b010, 3'b100, 3'b100, 3'b001),
                    3'd1, 3'd2, 3'd2, 3'd0, 3'b000, 5'b11111, 6};
        vecs[2] = '{"t3_inv_tie", 5'b11111,
                    bw(3'b100, 3'b100, 3'b011, 3'b010, 3'b010),
                    3'd0, 3'd2, 3'd2, 3'd1, 3'b000, 5'b11111, 6};
        vecs[3] = '{"t3_inv_win2", 5'b11111,
                    bw(3'b100, 3'b100, 3'b011, 3'b100, 3'b010),
                    3'd0, 3'd1, 3'd3, 3'd1, 3'b100, 5'b11111, 6};
        vecs[4] = '{"t4_timeout", 5'b00111,
                    bw(3'b001, 3'b010, 3'b001, 3'b001, 3'b001),
                    3'd2, 3'd1, 3'd0, 3'd0, 3'b001, 5'b00111, 17};
        vecs[5] = '{"all_invalid", 5'b11111,
                    bw(3'b000, 3'b111, 3'b110, 3'b101, 3'b000),
                    3'd0, 3'd0, 3'd0, 3'd5, 3'b000, 5'b11111, 6};
        vecs[6] = '{"no_req", 5'b00000, 15'd0,
                    3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 5'b00000, 17};

        req = 5'b0;
        ballot = 15'd0;
        do_reset();
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset voted", voted, 0);
        check("reset result", result, 0);
        check("reset cnt0", cnt0, 0);
        check("reset invalid", invalid_cnt, 0);
        check("reset grant", grant, 0);

        // Round-robin order over a full session.
        req = 5'b11111;
        ballot = vecs[0].ballot;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rr grant %0d", i), grant, 32'(5'b00001 << i));
            step();
        end
        check("rr tally grant", grant, 0);
        check("rr tally busy", busy, 1);
        check("rr tally done", done, 0);
        step();
        check("rr done", done, 1);
        check("rr result", result, 3'b001);

        for (int i = 0; i < 7; i++) run_session(vecs[i]);

        // Voter 0 keeps requesting after its ballot; search continues from ptr.
        do_reset();
        ballot = bw(3'b001, 3'b010, 3'b100, 3'b001, 3'b001);
        req = 5'b00001;
        start = 1'b1;
        step();
        start = 1'b0;
        check("dup grant0", grant, 5'b00001);
        req = 5'b01011;
        step();
        check("dup grant1", grant, 5'b00010);
        step();
        check("dup grant3", grant, 5'b01000);
        step();
        check("dup none", grant, 5'b00000);
        check("dup voted", voted, 5'b01011);
        check("dup cnt2", cnt2, 3'd0);
        check("dup cnt0", cnt0, 3'd2);

        // Start mid-OPEN ignored, then reset mid-OPEN.
        do_reset();
        ballot = bw(3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
        req = 5'b11111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("mid cnt0", cnt0, 3'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        check("mid start cnt0", cnt0, 3'd3);
        check("mid start voted", voted, 5'b00111);
        check("mid start busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid rst voted", voted, 0);
        check("mid rst cnt0", cnt0, 0);
        check("mid rst busy", busy, 0);
        check("mid rst done", done, 0);
        check("mid rst grant", grant, 0);
        step();
        check("idle grant", grant, 0);
        check("idle busy", busy, 0);
        run_session(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
Session controller and arbiter for the 5-voter, 3-candidate one-hot voting datapath. Five voters share one tally path. The block opens a voting session, grants one voter per cycle round-robin, and enforces one ballot per voter. It counts valid and invalid ballots, closes on all-voted or timeout, then publishes a one-hot winner or 000 on no majority.

Parameters:
TIMEOUT, 16, maximum cycles spent in OPEN before forced close (1..2^TW-1)
TW, 5, timer width in bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  open a session; honoured only in IDLE or DONE
req  input  5  per-voter request; bit i = voter i (A=0 .. E=4)
ballot  input  15  voter i ballot on bits [3i+2:3i]; legal values 001, 010, 100
grant  output  1x5  one-hot grant, combinational from state/ptr/req/voted; ballot sampled on the edge where grant[i]=1
voted  output  5  voter has cast a ballot this session (registered)
busy  output  1  high in OPEN and TALLY
done  output  1  high in DONE
result  output  3  winner, one-hot; 000 = no winner
cnt0  output  3  valid votes for candidate 001
cnt1  output  3  valid votes for candidate 010
cnt2  output  3  valid votes for candidate 100
invalid_cnt  output  3  ballots not one-hot (000, 011, 101, 110, 111)

Behaviour:
- Reset (rst=1 at edge): state IDLE, ptr=0, timer=0; voted, cnt0-2, invalid_cnt, result, busy, done all 0; grant=0. Reset has priority over every event, in any state.
- States: IDLE, OPEN, TALLY, DONE.
- IDLE: start=1 -> OPEN. On the same edge clear voted, counts, invalid_cnt, result, timer and ptr.
- DONE: start=1 -> OPEN with the same clears. Otherwise hold all outputs.
- OPEN/TALLY: start ignored.
- OPEN, each cycle: eligible = req & ~voted.
  - Grant the first eligible voter searching from ptr upward, modulo 5.
  - At most one grant per cycle; grant=0 when eligible=0.
- Accepting a grant to voter i:
  - If the ballot is one-hot, increment the matching cnt.
  - Otherwise increment invalid_cnt.
  - Set voted[i] either way; ptr <= (i+1) mod 5.
  - A voter with voted[i]=1 is never granted again in the session, even with req held high.
- Timer increments every OPEN cycle.
- Exit OPEN -> TALLY when the updated voted equals 11111, or when timer == TIMEOUT-1. If both hold on the same edge, the ballot accepted on that edge still counts.
- TALLY, one cycle:
  - result = one-hot candidate whose count is strictly greater than both others.
  - Any tie for highest, or zero valid votes, gives result=000.
  - Next state DONE.
- Latency: the final acceptance edge moves the FSM to TALLY. The next edge moves it to DONE and registers result. done is high from then on.
- Counts are 3 bits; the maximum is 5, so no overflow.
- grant is never asserted outside OPEN.

Test Plan:
1. Reset, start, req=11111, ballots A=001 B=001 C=010 D=100 E=001 -> grants 00001, 00010, 00100, 01000, 10000 on consecutive cycles; cnt0=3 cnt1=1 cnt2=1; result=001; done=1 two edges after the last grant.
2. Ballots A=010 B=010 C=100 D=100 E=001 -> tie 2/2/1, result=000, done=1, invalid_cnt=0.
3. C=011, others A=B=100 D=E=010 -> invalid_cnt=1, voted=11111, tie 2/2 -> result=000. Then repeat with D=100 -> result=100.
4. Timeout: req=00111 only, TIMEOUT=16 -> 3 grants, then TALLY after the 16th OPEN cycle; voted=00111, busy low and done high.
5. Round-robin and duplicate check: voter 0 requests alone and is granted, then keeps req high with req raised for voters 3 and 1 -> voter 0 never re-granted; next grants go to 1 then 3 (ptr search order).
6. Start pulse mid-OPEN -> ignored, counts unchanged. rst=1 mid-OPEN -> next cycle all outputs 0, state IDLE. A later start runs a clean session.
